// File: rtl/multi_issue.sv
// multi_issue: valid/ready front end that drives a start/done multi-cycle unit.
// Latency: start one cycle after accept; response one cycle after done, or TIMEOUT+2 cycles after accept.
// Backpressure: one request in flight; req_ready only in IDLE, RESP holds until rsp_ready.
module multi_issue #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 15
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_data,
   output logic             start,
   output logic [WIDTH-1:0] inp,
   input  logic             done,
   input  logic [WIDTH-1:0] out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_timeout,
   output logic             busy
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] inp_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic             rsp_timeout_q;

   // Single FSM: sequences one request through start, wait and response; done outside WAIT is stale.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         inp_q         <= '0;
         rsp_data_q    <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  inp_q   <= req_data;
                  state_q <= START;
               end
            end
            START: begin
               cnt_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               // done wins over the timeout when both land in the same cycle
               if (done) begin
                  rsp_data_q    <= out;
                  rsp_timeout_q <= 1'b0;
                  state_q       <= RESP;
               end else if (cnt_q == CNT_LAST) begin
                  rsp_data_q    <= '0;
                  rsp_timeout_q <= 1'b1;
                  state_q       <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Handshake and pulse outputs are pure decodes of the registered state.
   assign req_ready   = (state_q == IDLE);
   assign start       = (state_q == START);
   assign rsp_valid   = (state_q == RESP);
   assign busy        = (state_q != IDLE);
   assign inp         = inp_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_multi_issue.sv
// Bench for multi_issue: directed requests against a hand-driven unit model.
// Expected responses are queued at issue time and popped by a monitor on each handshake.
// Cycle-level protocol checks (start pulse, ready, busy, reset values) are done inline.
module tb_multi_issue;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset;
   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] req_data;
   logic         start;
   logic [W-1:0] inp;
   logic         done;
   logic [W-1:0] out;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_data;
   logic         rsp_timeout;
   logic         busy;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [W-1:0] data;
      logic         tmo;
   } exp_t;

   exp_t sb_q[$];

   multi_issue #(.WIDTH(W), .TIMEOUT(15)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .start      (start),
      .inp        (inp),
      .done       (done),
      .out        (out),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_timeout(rsp_timeout),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // advance to the start of the next cycle (just after the active edge)
   task automatic nxt();
      @(posedge clock);
      #1;
   endtask

   // settle point inside the current cycle where outputs are sampled
   task automatic mid();
      @(negedge clock);
   endtask

   // Monitor: every response handshake pops the oldest expectation.
   always @(negedge clock) begin
      if (!reset && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_unexpected: got data 0x%0h tmo %0b, expected no response", rsp_data, rsp_timeout);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("rsp_data", rsp_data, e.data);
            check("rsp_timeout", W'(rsp_timeout), W'(e.tmo));
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_req_ready"}, W'(req_ready), 1);
      check({tag, "_start"}, W'(start), 0);
      check({tag, "_rsp_valid"}, W'(rsp_valid), 0);
      check({tag, "_rsp_timeout"}, W'(rsp_timeout), 0);
      check({tag, "_busy"}, W'(busy), 0);
      check({tag, "_inp"}, inp, 0);
      check({tag, "_rsp_data"}, rsp_data, 0);
   endtask

   // issue a request in the current cycle and queue its expected response
   task automatic accept(input logic [W-1:0] d, input logic [W-1:0] exp_d, input logic exp_t_o, input bit expect_rsp);
      exp_t e;
      req_valid = 1'b1;
      req_data  = d;
      if (expect_rsp) begin
         e.data = exp_d;
         e.tmo  = exp_t_o;
         sb_q.push_back(e);
      end
      mid();
      check("accept_req_ready", W'(req_ready), 1);
      nxt();
      req_valid = 1'b0;
      req_data  = '0;
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_data = '0;
      done = 1'b0; out = '0; rsp_ready = 1'b1;
      nxt(); nxt();
      reset = 1'b0;
      mid();
      check_reset_vals("rst");
      nxt();

      // 1: basic, done at T+4 -> response at T+5
      accept(32'h5, 32'h55, 1'b0, 1'b1);
      mid(); check("t1_start_T1", W'(start), 1); check("t1_inp_T1", inp, 32'h5);
      check("t1_req_ready_T1", W'(req_ready), 0);
      nxt();
      mid(); check("t1_start_T2", W'(start), 0); check("t1_busy_T2", W'(busy), 1);
      nxt(); nxt();
      done = 1'b1; out = 32'h55;
      mid(); check("t1_rsp_valid_T4", W'(rsp_valid), 0);
      nxt();
      done = 1'b0; out = '0;
      mid(); check("t1_rsp_valid_T5", W'(rsp_valid), 1); check("t1_inp_hold", inp, 32'h5);
      nxt();
      mid(); check("t1_idle_ready", W'(req_ready), 1); check("t1_idle_busy", W'(busy), 0);
      nxt();

      // 2: backpressure in RESP with a competing request
      accept(32'h11, 32'h22, 1'b0, 1'b1);
      nxt();
      done = 1'b1; out = 32'h22;
      nxt();
      done = 1'b0; out = '0;
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_data = 32'hAA;
      for (int i = 0; i < 4; i++) begin
         mid();
         check("t2_rsp_valid", W'(rsp_valid), 1);
         check("t2_rsp_data_stable", rsp_data, 32'h22);
         check("t2_req_ready", W'(req_ready), 0);
         check("t2_inp_not_taken", inp, 32'h11);
         nxt();
      end
      rsp_ready = 1'b1;
      sb_q.push_back('{data: 32'hAB, tmo: 1'b0});
      mid(); check("t2_release_valid", W'(rsp_valid), 1);
      nxt();
      mid(); check("t2_aa_ready", W'(req_ready), 1);
      nxt();
      req_valid = 1'b0; req_data = '0;
      mid(); check("t2_aa_start", W'(start), 1); check("t2_aa_inp", inp, 32'hAA);
      nxt();
      done = 1'b1; out = 32'hAB;
      nxt();
      done = 1'b0; out = '0;
      nxt();

      // 3: timeout, no done -> response at T+17
      accept(32'h33, 32'h0, 1'b1, 1'b1);
      for (int c = 1; c <= 15; c++) begin
         nxt();
      end
      mid(); check("t3_rsp_valid_T16", W'(rsp_valid), 0); check("t3_busy_T16", W'(busy), 1);
      nxt();
      mid(); check("t3_rsp_valid_T17", W'(rsp_valid), 1); check("t3_busy_T17", W'(busy), 1);
      nxt();
      mid(); check("t3_busy_after", W'(busy), 0);
      nxt();

      // 4: done at counter 14 (T+16) still wins over timeout
      accept(32'h44, 32'h1234, 1'b0, 1'b1);
      for (int c = 1; c <= 14; c++) begin
         nxt();
      end
      nxt();
      done = 1'b1; out = 32'h1234;
      mid(); check("t4_rsp_valid_T16", W'(rsp_valid), 0);
      nxt();
      done = 1'b0; out = '0;
      mid(); check("t4_rsp_valid_T17", W'(rsp_valid), 1);
      nxt();

      // 5: stale done in IDLE and in START
      done = 1'b1; out = 32'hDEAD;
      mid(); check("t5_idle_busy", W'(busy), 0);
      nxt();
      done = 1'b0; out = '0;
      mid(); check("t5_idle_still", W'(busy), 0); check("t5_no_rsp", W'(rsp_valid), 0);
      nxt();
      accept(32'h55, 32'h7, 1'b0, 1'b1);
      done = 1'b1; out = 32'hDEAD;
      mid(); check("t5_start", W'(start), 1);
      nxt();
      done = 1'b0; out = '0;
      mid(); check("t5_wait_busy", W'(busy), 1); check("t5_wait_no_rsp", W'(rsp_valid), 0);
      nxt();
      done = 1'b1; out = 32'h7;
      nxt();
      done = 1'b0; out = '0;
      mid(); check("t5_rsp_valid", W'(rsp_valid), 1);
      nxt();

      // 6: reset mid-WAIT, later done ignored, no response ever
      accept(32'h66, 32'h0, 1'b0, 1'b0);
      nxt(); nxt();
      reset = 1'b1;
      nxt();
      reset = 1'b0;
      done = 1'b1; out = 32'h99;
      mid();
      check_reset_vals("t6");
      nxt();
      done = 1'b0; out = '0;
      for (int c = 0; c < 20; c++) begin
         mid();
         check("t6_no_rsp", W'(rsp_valid), 0);
         nxt();
      end
      check("t6_state_idle", W'(busy), 0);

      check("sb_drained", W'(sb_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
